riscv_mc_control: RTL and testbench
===================================

Name: riscv_mc_control

Overview:
Multicycle main controller for the RV32 subset core. It is the producer side of the ALU interface. It decodes op/funct3/funct7b5 into alu_control, sequences the shared datapath through an FSM, and consumes the ALU flags to resolve branches. All datapath enables and mux selects come from this block.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: an illegal encoding enters HALT and sets sticky illegal_op; 0: an illegal encoding is treated as a NOP and the FSM returns to FETCH.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  instr[6:0] from IR; stable from DECODE to end of instruction
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero_flag  in  1  ALU result == 0
negative_flag  in  1  ALU result[31]
overflow_flag  in  1  signed overflow of current ALU op
pc_write  out  1  PC load enable
adr_src  out  1  memory address: 0=PC, 1=ALUOut
mem_write  out  1  data memory write enable
ir_write  out  1  IR/oldPC load enable
result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result
alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1
alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
alu_control  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
imm_src  out  2  00=I, 01=S, 10=B, 11=J
reg_write  out  1  register file write enable
illegal_op  out  1  sticky illegal-encoding flag
state_o  out  4  current state encoding (debug)

Behaviour:
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, HALT 11.
- Reset: state=FETCH, illegal_op=0. While rst_n=0, pc_write, ir_write, mem_write and reg_write are forced to 0. A mid-instruction reset abandons the instruction with no write.
- Outputs are Moore, decoded from state. The one exception is pc_write in BRANCH, which is a function of state plus flags. Any output not listed for a state is 0, and alu_control defaults to ADD.
- FETCH: adr_src=0, ir_write=1, a=00, b=10, ADD, result_src=10, pc_write=1. Next state is DECODE.
- DECODE: a=01, b=01, ADD (computes branch target).
  - op 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> illegal
- MEMADR: a=10, b=01, ADD. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1 -> MEMWB. MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: adr_src=1, mem_write=1 -> FETCH.
- EXECR: a=10, b=00. EXECI: a=10, b=01. Both go to ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: a=10, b=00, SUB, result_src=00. pc_write=taken, where:
  - 000 beq: zero
  - 001 bne: ~zero
  - 100 blt: neg^ovf
  - 101 bge: ~(neg^ovf)
  - Next state is FETCH whether or not the branch is taken.
- JAL: a=01, b=10, ADD, result_src=00, pc_write=1 -> ALUWB (rd=PC+4).
- ALU decode for EXECR/EXECI:
  - funct3 000: SUB if R-type and funct7b5=1, else ADD (funct7b5 is ignored for I-type).
  - 010 SLT, 110 OR, 111 AND.
  - Any other funct3 is illegal.
- Illegal encodings (bad op, bad ALU funct3, bad branch funct3) are detected in DECODE, and no write enable is asserted for them.
  - TRAP_ON_ILLEGAL=1: go to HALT, illegal_op<=1. HALT holds all enables at 0 until reset.
  - TRAP_ON_ILLEGAL=0: go to FETCH, illegal_op stays 0.
- imm_src is combinational from op:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - anything else -> 00
- Latency (FETCH to next FETCH): lw 5, sw 4, R 4, I 4, branch 3, jal 4.

Optional Feature:
Macro: MC_CTRL_BRANCH_EXT_EN.
- Defined: bne, blt and bge are decoded as specified above.
- Undefined: only beq (funct3 000) is legal, and branch funct3 values 001/100/101 take the illegal path.

Test Plan:
- Reset then release; op=0110011, f3=000, f7b5=1 -> states 0,1,6,8,0; alu_control=001 in EXECR; reg_write=1 only in ALUWB.
- lw (op=0000011) -> states 0,1,2,3,4 with adr_src=1 in MEMREAD and result_src=01, reg_write=1 in MEMWB; sw (0100011) -> mem_write=1 for exactly 1 cycle in MEMWRITE.
- beq with zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; bne inverts. With the macro: blt, neg=1, ovf=0 -> taken; neg=1, ovf=1 -> not taken.
- jal (1101111) -> states 0,1,10,8,0; imm_src=11; pc_write=1 in JAL.
- op=1111111 with TRAP_ON_ILLEGAL=1 -> HALT (state_o=11), illegal_op=1, no enables thereafter; with =0 -> FETCH and illegal_op=0.
- Assert rst_n=0 during MEMWRITE -> mem_write drops to 0 immediately (asynchronously), state_o=0; after release the FSM runs from FETCH.

Source files
------------

// File: rtl/riscv_mc_control.sv
// riscv_mc_control
//   Multicycle main controller for the RV32 subset core. It decodes
//   op/funct3/funct7b5 into alu_control, steps the shared datapath through a
//   Moore FSM and uses the ALU flags to resolve conditional branches.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   op, funct3, funct7b5  instruction fields from IR (stable from DECODE on)
//   zero/negative/overflow_flag  ALU flags, used only in BRANCH
//   pc_write, adr_src, mem_write, ir_write, result_src,
//   alu_src_a, alu_src_b, alu_control, imm_src, reg_write
//                         datapath enables and mux selects
//   illegal_op            sticky illegal-encoding flag (trap build only)
//   state_o               current state encoding, for debug
//
// Parameters
//   TRAP_ON_ILLEGAL  1: illegal encoding -> HALT and illegal_op set
//                    0: illegal encoding is a NOP, back to FETCH
//
// Build option
//   MC_CTRL_BRANCH_EXT_EN  defined: bne/blt/bge are legal branches.
//                          undefined: only beq is legal.
module riscv_mc_control #(
  parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero_flag,
  input  logic       negative_flag,
  input  logic       overflow_flag,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Moore control word decoded from state
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write;
  } ctrl_t;

  state_t state, state_nxt;
  ctrl_t  ctrl;
  logic   illegal_q;

  logic       alu_f3_ok;
  logic [2:0] alu_dec;
  logic       br_f3_ok;
  logic       br_taken;
  logic       dec_illegal;
  logic       lt;

  // ALU op for EXECR/EXECI; funct7b5 selects SUB only for R-type
  always_comb begin
    alu_f3_ok = 1'b1;
    alu_dec   = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_f3_ok = 1'b0;
    endcase
  end

  // signed less-than from SUB flags
  assign lt = negative_flag ^ overflow_flag;

  always_comb begin
    br_f3_ok = 1'b0;
    br_taken = 1'b0;
    case (funct3)
      3'b000: begin br_f3_ok = 1'b1; br_taken = zero_flag;  end
`ifdef MC_CTRL_BRANCH_EXT_EN
      3'b001: begin br_f3_ok = 1'b1; br_taken = ~zero_flag; end
      3'b100: begin br_f3_ok = 1'b1; br_taken = lt;         end
      3'b101: begin br_f3_ok = 1'b1; br_taken = ~lt;        end
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_LOAD, OP_STORE, OP_JAL: dec_illegal = 1'b0;
      OP_R, OP_I:                dec_illegal = ~alu_f3_ok;
      OP_BRANCH:                 dec_illegal = ~br_f3_ok;
      default:                   dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE && dec_illegal && TRAP_ON_ILLEGAL != 0)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.pc_write   = 1'b1;
        state_nxt       = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut <= oldPC + imm, the branch target
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b01;
        if (dec_illegal)
          state_nxt = (TRAP_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
        else begin
          case (op)
            OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
            OP_R:              state_nxt = S_EXECR;
            OP_I:              state_nxt = S_EXECI;
            OP_BRANCH:         state_nxt = S_BRANCH;
            default:           state_nxt = S_JAL;
          endcase
        end
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        state_nxt      = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctrl.adr_src = 1'b1;
        state_nxt    = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_EXECR: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_control = alu_dec;
        state_nxt        = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_src_b   = 2'b01;
        ctrl.alu_control = alu_dec;
        state_nxt        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_BRANCH: begin
        // rs1 - rs2 sets the flags; PC loads the target held in ALUOut
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_control = ALU_SUB;
        ctrl.pc_write    = br_taken;
        state_nxt        = S_FETCH;
      end
      S_JAL: begin
        // PC <= target from ALUOut while the ALU forms oldPC+4 for rd
        ctrl.alu_src_a  = 2'b01;
        ctrl.alu_src_b  = 2'b10;
        ctrl.pc_write   = 1'b1;
        state_nxt       = S_ALUWB;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // write enables are masked while reset is held: state is FETCH then,
  // which would otherwise assert pc_write/ir_write
  assign pc_write    = ctrl.pc_write  & rst_n;
  assign ir_write    = ctrl.ir_write  & rst_n;
  assign mem_write   = ctrl.mem_write & rst_n;
  assign reg_write   = ctrl.reg_write & rst_n;
  assign adr_src     = ctrl.adr_src;
  assign result_src  = ctrl.result_src;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_control = ctrl.alu_control;
  assign illegal_op  = illegal_q;
  assign state_o     = state;

endmodule

// File: tb/tb_riscv_mc_control.sv
module tb_riscv_mc_control;

  logic       clk, rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zf, nf, vf;

  logic       t_pcw, t_adr, t_mw, t_irw, t_rw, t_ill;
  logic [1:0] t_rs, t_a, t_b, t_imm;
  logic [2:0] t_alu;
  logic [3:0] t_st;
  logic       n_pcw, n_adr, n_mw, n_irw, n_rw, n_ill;
  logic [1:0] n_rs, n_a, n_b, n_imm;
  logic [2:0] n_alu;
  logic [3:0] n_st;

  riscv_mc_control #(.TRAP_ON_ILLEGAL(1)) u_trap (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero_flag(zf), .negative_flag(nf), .overflow_flag(vf),
    .pc_write(t_pcw), .adr_src(t_adr), .mem_write(t_mw), .ir_write(t_irw),
    .result_src(t_rs), .alu_src_a(t_a), .alu_src_b(t_b), .alu_control(t_alu),
    .imm_src(t_imm), .reg_write(t_rw), .illegal_op(t_ill), .state_o(t_st));

  riscv_mc_control #(.TRAP_ON_ILLEGAL(0)) u_nop (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero_flag(zf), .negative_flag(nf), .overflow_flag(vf),
    .pc_write(n_pcw), .adr_src(n_adr), .mem_write(n_mw), .ir_write(n_irw),
    .result_src(n_rs), .alu_src_a(n_a), .alu_src_b(n_b), .alu_control(n_alu),
    .imm_src(n_imm), .reg_write(n_rw), .illegal_op(n_ill), .state_o(n_st));

  // {state, illegal, pc_write, adr_src, mem_write, ir_write,
  //  result_src, a, b, alu_control, imm_src, reg_write}
  logic [20:0] t_vec, n_vec;
  assign t_vec = {t_st, t_ill, t_pcw, t_adr, t_mw, t_irw, t_rs, t_a, t_b, t_alu, t_imm, t_rw};
  assign n_vec = {n_st, n_ill, n_pcw, n_adr, n_mw, n_irw, n_rs, n_a, n_b, n_alu, n_imm, n_rw};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int want[$];

  task automatic chk(input string name, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit branch_legal(input logic [2:0] f);
`ifdef MC_CTRL_BRANCH_EXT_EN
    return (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5);
`else
    return (f == 3'd0);
`endif
  endfunction

  function automatic bit alu_legal(input logic [2:0] f);
    return (f == 3'd0 || f == 3'd2 || f == 3'd6 || f == 3'd7);
  endfunction

  function automatic logic branch_taken();
    case (funct3)
      3'd0:    return zf;
      3'd1:    return !zf;
      3'd4:    return nf != vf;
      default: return nf == vf;
    endcase
  endfunction

  function automatic logic [2:0] alu_for(input bit is_r);
    case (funct3)
      3'd0:    return (is_r && funct7b5) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // expected state walk of one instruction, FETCH first; returns 1 if the
  // instruction is illegal (walk stops after DECODE)
  function automatic bit model_seq(input logic [6:0] o, input logic [2:0] f);
    want.delete();
    want.push_back(0);
    want.push_back(1);
    case (o)
      7'b0000011: begin want.push_back(2); want.push_back(3); want.push_back(4); end
      7'b0100011: begin want.push_back(2); want.push_back(5); end
      7'b0110011: if (alu_legal(f)) begin want.push_back(6); want.push_back(8); end else return 1;
      7'b0010011: if (alu_legal(f)) begin want.push_back(7); want.push_back(8); end else return 1;
      7'b1100011: if (branch_legal(f)) want.push_back(9); else return 1;
      7'b1101111: begin want.push_back(10); want.push_back(8); end
      default:    return 1;
    endcase
    return 0;
  endfunction

  function automatic logic [20:0] exp_vec(input int st, input logic ill, input logic in_rst);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu;
    logic [3:0] s4;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; rs = 0; a = 0; b = 0; alu = 0;
    s4 = st[3:0];
    imm = (op == 7'b0100011) ? 2'd1 : (op == 7'b1100011) ? 2'd2 :
          (op == 7'b1101111) ? 2'd3 : 2'd0;
    case (st)
      0:  begin irw = 1; b = 2; rs = 2; pcw = 1; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2; alu = alu_for(1); end
      7:  begin a = 2; b = 1; alu = alu_for(0); end
      8:  rw = 1;
      9:  begin a = 2; alu = 3'b001; pcw = branch_taken(); end
      10: begin a = 1; b = 2; pcw = 1; end
      default: ;
    endcase
    if (in_rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    return {s4, ill, pcw, adr, mw, irw, rs, a, b, alu, imm, rw};
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_trap", t_vec, exp_vec(0, 0, 1));
    chk("rst_nop",  n_vec, exp_vec(0, 0, 1));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // called at posedge+1 with both DUTs in FETCH; walks the expected states
  // held in want, then handles the illegal tail if ill is set
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f,
                           input logic f7, input logic z, input logic n, input logic v,
                           input bit ill);
    op = o; funct3 = f; funct7b5 = f7; zf = z; nf = n; vf = v;
    foreach (want[i]) begin
      @(negedge clk);
      chk({tag, "_trap"}, t_vec, exp_vec(want[i], 0, 0));
      chk({tag, "_nop"},  n_vec, exp_vec(want[i], 0, 0));
      @(posedge clk); #1;
    end
    if (ill) begin
      @(negedge clk);
      chk({tag, "_halt"},  t_vec, exp_vec(11, 1, 0));
      chk({tag, "_nopfetch"}, n_vec, exp_vec(0, 0, 0));
      repeat (2) begin
        @(posedge clk); #1;
        zf = 1'($urandom); nf = 1'($urandom); vf = 1'($urandom);
        @(negedge clk);
        chk({tag, "_halthold"}, t_vec, exp_vec(11, 1, 0));
      end
      @(posedge clk); #1;
      do_reset();
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, z, n, v;
    int          len;
    logic [23:0] st;   // state list, first state in the low nibble
    bit          ill;
  } vec_t;

  vec_t tbl[$];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  initial begin
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    zf = 1'b0; nf = 1'b0; vf = 1'b0;

    tbl.push_back('{RT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 24'h008610, 1'b0}); // sub
    tbl.push_back('{RT, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4, 24'h008610, 1'b0}); // and
    tbl.push_back('{IT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 24'h008710, 1'b0}); // addi, f7 ignored
    tbl.push_back('{IT, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4, 24'h008710, 1'b0}); // slti
    tbl.push_back('{LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5, 24'h043210, 1'b0});
    tbl.push_back('{SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4, 24'h005210, 1'b0});
    tbl.push_back('{BR, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 24'h000910, 1'b0}); // beq taken
    tbl.push_back('{BR, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 24'h000910, 1'b0}); // beq not taken
`ifdef MC_CTRL_BRANCH_EXT_EN
    tbl.push_back('{BR, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 24'h000910, 1'b0}); // bne not taken
    tbl.push_back('{BR, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 24'h000910, 1'b0}); // bne taken
    tbl.push_back('{BR, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 3, 24'h000910, 1'b0}); // blt taken
    tbl.push_back('{BR, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 3, 24'h000910, 1'b0}); // blt not taken
    tbl.push_back('{BR, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 3, 24'h000910, 1'b0}); // bge taken
`else
    tbl.push_back('{BR, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 24'h000010, 1'b1}); // bne illegal
    tbl.push_back('{BR, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2, 24'h000010, 1'b1}); // blt illegal
`endif
    tbl.push_back('{BR, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2, 24'h000010, 1'b1}); // bad branch f3
    tbl.push_back('{JL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 24'h008A10, 1'b0});
    tbl.push_back('{7'h7F, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 24'h000010, 1'b1}); // bad op
    tbl.push_back('{RT, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 24'h000010, 1'b1});   // bad alu f3

    #2;
    do_reset();

    foreach (tbl[k]) begin
      logic [23:0] s;
      s = tbl[k].st;
      want.delete();
      for (int j = 0; j < tbl[k].len; j++) want.push_back(int'(s[4*j +: 4]));
      run_instr($sformatf("tbl%0d", k), tbl[k].op, tbl[k].f3, tbl[k].f7,
                tbl[k].z, tbl[k].n, tbl[k].v, tbl[k].ill);
    end

    // reset in MEMWRITE: mem_write must drop without waiting for a clock
    op = SW; funct3 = 3'd2; funct7b5 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("mr_walk", t_vec, exp_vec(j == 0 ? 0 : j == 1 ? 1 : 2, 0, 0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1("mr_memwrite_hi", t_mw, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mr_memwrite_lo", t_mw, 1'b0);
    chk("mr_async_trap", t_vec, exp_vec(0, 0, 1));
    chk("mr_async_nop",  n_vec, exp_vec(0, 0, 1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      bit il;
      il = model_seq(LW, 3'd2);
      run_instr("mr_after", LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, il);
    end

    // randomized instruction stream against the model
    for (int r = 0; r < 200; r++) begin
      logic [6:0] o;
      logic [2:0] f;
      bit il;
      case ($urandom_range(0, 6))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BR;
        5: o = JL;
        default: o = 7'($urandom);
      endcase
      f = 3'($urandom);
      il = model_seq(o, f);
      run_instr("rnd", o, f, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), il);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
